// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, engine and completion signals of the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  io_buffer_full;
  logic                  icache_valid;
  logic [ADDR_WIDTH-1:0] icache_addr;
  logic                  icache_ready;
  logic [LINE_WIDTH-1:0] icache_data;
  logic                  dcache_valid;
  logic                  dcache_rw;
  logic [ADDR_WIDTH-1:0] dcache_addr;
  logic [LINE_WIDTH-1:0] dcache_wdata;
  logic                  dcache_ready;
  logic [LINE_WIDTH-1:0] dcache_rdata;
  logic                  io_valid;
  logic                  io_rw;
  logic [ADDR_WIDTH-1:0] io_addr;
  logic [7:0]            io_wdata;
  logic                  io_ready;
  logic [7:0]            io_rdata;
  logic                  eng_valid;
  logic [1:0]            eng_kind;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [LINE_WIDTH-1:0] eng_wdata;
  logic                  eng_ready;
  logic                  eng_done;
  logic [LINE_WIDTH-1:0] eng_rdata;

  modport slave (
    input  io_buffer_full,
    input  icache_valid, icache_addr,
    output icache_ready, icache_data,
    input  dcache_valid, dcache_rw, dcache_addr, dcache_wdata,
    output dcache_ready, dcache_rdata,
    input  io_valid, io_rw, io_addr, io_wdata,
    output io_ready, io_rdata,
    output eng_valid, eng_kind, eng_addr, eng_wdata,
    input  eng_ready, eng_done, eng_rdata
  );

  modport master (
    output io_buffer_full,
    output icache_valid, icache_addr,
    input  icache_ready, icache_data,
    output dcache_valid, dcache_rw, dcache_addr, dcache_wdata,
    input  dcache_ready, dcache_rdata,
    output io_valid, io_rw, io_addr, io_wdata,
    input  io_ready, io_rdata,
    input  eng_valid, eng_kind, eng_addr, eng_wdata,
    output eng_ready, eng_done, eng_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - grants icache/dcache/io requests one at a time to the memory transfer engine
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] OWN_IC = 2'd0;
  localparam logic [1:0] OWN_DC = 2'd1;
  localparam logic [1:0] OWN_IO = 2'd2;

  localparam logic [1:0] K_LINE_RD = 2'd0;
  localparam logic [1:0] K_LINE_WR = 2'd1;
  localparam logic [1:0] K_BYTE_RD = 2'd2;
  localparam logic [1:0] K_BYTE_WR = 2'd3;

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic [1:0]            state_q, state_d;
  logic [1:0]            owner_q, owner_d;
  logic                  last_dc_q, last_dc_d;
  logic [2:0]            starve_q, starve_d;
  logic                  eng_valid_q, eng_valid_d;
  logic [1:0]            eng_kind_q, eng_kind_d;
  logic [ADDR_WIDTH-1:0] eng_addr_q, eng_addr_d;
  logic [LINE_WIDTH-1:0] eng_wdata_q, eng_wdata_d;
  logic                  ic_ready_q, ic_ready_d;
  logic                  dc_ready_q, dc_ready_d;
  logic                  io_ready_q, io_ready_d;
  logic [LINE_WIDTH-1:0] ic_data_q, ic_data_d;
  logic [LINE_WIDTH-1:0] dc_data_q, dc_data_d;
  logic [7:0]            io_data_q, io_data_d;

  logic ic_elig, dc_elig, io_elig, cache_elig, starved, pick_dc;

  always_comb begin
    ic_elig    = bus.icache_valid;
    dc_elig    = bus.dcache_valid;
    io_elig    = bus.io_valid && (!bus.io_rw || !bus.io_buffer_full);
    cache_elig = ic_elig || dc_elig;
    starved    = (starve_q >= STARVE_MAX) && cache_elig;
    // last_dc_q=1 means dcache had the previous cache grant, so icache wins a tie
    pick_dc    = dc_elig && (!ic_elig || !last_dc_q);

    state_d     = state_q;
    owner_d     = owner_q;
    last_dc_d   = last_dc_q;
    starve_d    = starve_q;
    eng_kind_d  = eng_kind_q;
    eng_addr_d  = eng_addr_q;
    eng_wdata_d = eng_wdata_q;
    ic_data_d   = ic_data_q;
    dc_data_d   = dc_data_q;
    io_data_d   = io_data_q;

    case (state_q)
      S_IDLE: begin
        if (io_elig && !starved) begin
          state_d     = S_ISSUE;
          owner_d     = OWN_IO;
          eng_kind_d  = bus.io_rw ? K_BYTE_WR : K_BYTE_RD;
          eng_addr_d  = bus.io_addr;
          eng_wdata_d = {{(LINE_WIDTH-8){1'b0}}, bus.io_wdata};
          if (!cache_elig)
            starve_d = 3'd0;
          else if (starve_q < STARVE_MAX)
            starve_d = starve_q + 3'd1;
        end else if (cache_elig) begin
          state_d  = S_ISSUE;
          starve_d = 3'd0;
          if (pick_dc) begin
            owner_d     = OWN_DC;
            last_dc_d   = 1'b1;
            eng_kind_d  = bus.dcache_rw ? K_LINE_WR : K_LINE_RD;
            eng_addr_d  = {bus.dcache_addr[ADDR_WIDTH-1:4], 4'b0};
            eng_wdata_d = bus.dcache_wdata;
          end else begin
            owner_d     = OWN_IC;
            last_dc_d   = 1'b0;
            eng_kind_d  = K_LINE_RD;
            eng_addr_d  = {bus.icache_addr[ADDR_WIDTH-1:4], 4'b0};
            eng_wdata_d = '0;
          end
        end else begin
          starve_d = 3'd0;
        end
      end
      S_ISSUE: begin
        if (bus.eng_ready)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_done) begin
          state_d = S_RESP;
          case (owner_q)
            OWN_IC:  ic_data_d = bus.eng_rdata;
            OWN_DC:  dc_data_d = bus.eng_rdata;
            default: io_data_d = bus.eng_rdata[7:0];
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    eng_valid_d = (state_d == S_ISSUE);
    ic_ready_d  = (state_d == S_RESP) && (owner_d == OWN_IC);
    dc_ready_d  = (state_d == S_RESP) && (owner_d == OWN_DC);
    io_ready_d  = (state_d == S_RESP) && (owner_d == OWN_IO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IC;
      last_dc_q   <= 1'b1;
      starve_q    <= 3'd0;
      eng_valid_q <= 1'b0;
      eng_kind_q  <= 2'd0;
      eng_addr_q  <= '0;
      eng_wdata_q <= '0;
      ic_ready_q  <= 1'b0;
      dc_ready_q  <= 1'b0;
      io_ready_q  <= 1'b0;
      ic_data_q   <= '0;
      dc_data_q   <= '0;
      io_data_q   <= 8'd0;
    end else if (rdy) begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_dc_q   <= last_dc_d;
      starve_q    <= starve_d;
      eng_valid_q <= eng_valid_d;
      eng_kind_q  <= eng_kind_d;
      eng_addr_q  <= eng_addr_d;
      eng_wdata_q <= eng_wdata_d;
      ic_ready_q  <= ic_ready_d;
      dc_ready_q  <= dc_ready_d;
      io_ready_q  <= io_ready_d;
      ic_data_q   <= ic_data_d;
      dc_data_q   <= dc_data_d;
      io_data_q   <= io_data_d;
    end
  end

  assign bus.eng_valid    = eng_valid_q;
  assign bus.eng_kind     = eng_kind_q;
  assign bus.eng_addr     = eng_addr_q;
  assign bus.eng_wdata    = eng_wdata_q;
  assign bus.icache_ready = ic_ready_q;
  assign bus.dcache_ready = dc_ready_q;
  assign bus.io_ready     = io_ready_q;
  assign bus.icache_data  = ic_data_q;
  assign bus.dcache_rdata = dc_data_q;
  assign bus.io_rdata     = io_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int SL = 4;
  localparam logic [LW-1:0] FIX_RDATA = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [LW-1:0] data;
  } resp_t;

  int n_pass = 0;
  int n_total = 0;

  int ic_pct, dc_pct, io_pct, dc_mode, io_mode, rdy_pct, erdy_pct, full_pct, spur_pct;
  int dly_min, dly_max;
  bit full_force, ic_fix, io_fix, rd_fix, lat_chk;

  int cyc = 0;
  int ic_raise_cyc = 0;
  bit eng_busy, done_real;
  int eng_cnt;
  resp_t exp_q[$];
  int done_cnt[3];

  int model_owner;
  int m_starve;
  bit m_last_dc;
  bit s_ic, s_dc, s_io, ev_prev;
  logic [1:0]    exp_kind;
  logic [AW-1:0] exp_addr;
  logic [LW-1:0] exp_wdata;
  bit            exp_wchk;
  logic [LW-1:0] last_ic, last_dc;
  logic [7:0]    last_io;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference arbitration: io wins unless the caches have waited through SL io grants;
  // a cache tie goes to whichever cache did not receive the previous cache grant.
  function automatic int model_grant(input bit e_ic, input bit e_dc, input bit e_io);
    bit any_cache = e_ic || e_dc;
    if (e_io && !(m_starve == SL && any_cache)) begin
      m_starve = any_cache ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
      return 2;
    end
    if (!any_cache) return -1;
    m_starve = 0;
    if (e_ic && e_dc) m_last_dc = !m_last_dc;
    else m_last_dc = e_dc;
    return m_last_dc ? 1 : 0;
  endfunction

  initial begin : driver
    bit hs, dn, ic_end, dc_end, io_end;
    bus.io_buffer_full = 0; bus.icache_valid = 0; bus.icache_addr = '0;
    bus.dcache_valid = 0; bus.dcache_rw = 0; bus.dcache_addr = '0; bus.dcache_wdata = '0;
    bus.io_valid = 0; bus.io_rw = 0; bus.io_addr = '0; bus.io_wdata = '0;
    bus.eng_ready = 0; bus.eng_done = 0; bus.eng_rdata = '0;
    forever begin
      @(negedge clk);
      hs     = rst && bus.eng_valid && bus.eng_ready && rdy;
      dn     = rst && done_real && rdy;
      ic_end = rst && bus.icache_ready && rdy;
      dc_end = rst && bus.dcache_ready && rdy;
      io_end = rst && bus.io_ready && rdy;
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        if (ic_end) bus.icache_valid = 0;
        if (!bus.icache_valid && pct(ic_pct)) begin
          bus.icache_valid = 1;
          bus.icache_addr  = ic_fix ? 32'h0000_1234 : {4'h1, 28'($urandom())};
          ic_raise_cyc     = cyc;
        end
        if (dc_end) bus.dcache_valid = 0;
        if (!bus.dcache_valid && pct(dc_pct)) begin
          bus.dcache_valid = 1;
          bus.dcache_rw    = (dc_mode == 2) ? 1'($urandom_range(1, 0)) : (dc_mode == 1);
          bus.dcache_addr  = {4'h2, 28'($urandom())};
          bus.dcache_wdata = rand_line();
        end
        if (io_end) bus.io_valid = 0;
        if (!bus.io_valid && pct(io_pct)) begin
          bus.io_valid = 1;
          bus.io_rw    = io_fix ? 1'b1 : ((io_mode == 2) ? 1'($urandom_range(1, 0)) : (io_mode == 1));
          bus.io_addr  = io_fix ? 32'h0003_0000 : {4'h3, 28'($urandom())};
          bus.io_wdata = io_fix ? 8'h41 : 8'($urandom());
        end
        if (dn) begin eng_busy = 0; done_real = 0; end
        if (hs) begin eng_busy = 1; eng_cnt = int'($urandom_range(dly_max, dly_min)); end
        if (!done_real) bus.eng_rdata = rand_line();
        if (eng_busy && !done_real) begin
          if (eng_cnt == 0) begin
            done_real = 1;
            bus.eng_rdata = rd_fix ? FIX_RDATA : rand_line();
            exp_q.push_back('{model_owner, bus.eng_rdata});
          end else eng_cnt--;
        end
        bus.eng_done       = done_real || (!eng_busy && pct(spur_pct));
        bus.eng_ready      = pct(erdy_pct);
        rdy                = pct(rdy_pct);
        bus.io_buffer_full = full_force || pct(full_pct);
      end
    end
  end

  initial begin : monitor
    int own, nr, port;
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.eng_valid && !ev_prev) begin
          own = model_grant(s_ic, s_dc, s_io);
          model_owner = own;
          chk("grant_expected", (own >= 0), 1);
          exp_wchk = 1;
          case (own)
            0: begin exp_kind = 2'd0; exp_addr = bus.icache_addr & ~32'hF; exp_wchk = 0; end
            1: begin
              exp_kind  = bus.dcache_rw ? 2'd1 : 2'd0;
              exp_addr  = bus.dcache_addr & ~32'hF;
              exp_wdata = bus.dcache_wdata;
              exp_wchk  = bus.dcache_rw;
            end
            default: begin
              exp_kind  = bus.io_rw ? 2'd3 : 2'd2;
              exp_addr  = bus.io_addr;
              exp_wdata = LW'(bus.io_wdata);
            end
          endcase
        end
        if (bus.eng_valid) begin
          chk("eng_kind", bus.eng_kind, exp_kind);
          chk("eng_addr", bus.eng_addr, exp_addr);
          if (exp_wchk) chk("eng_wdata", bus.eng_wdata, exp_wdata);
        end
        nr = int'(bus.icache_ready) + int'(bus.dcache_ready) + int'(bus.io_ready);
        if (nr != 0 && rdy) begin
          chk("single_ready", nr, 1);
          port = bus.icache_ready ? 0 : (bus.dcache_ready ? 1 : 2);
          if (exp_q.size() == 0) chk("resp_expected", 0, 1);
          else begin
            e = exp_q.pop_front();
            chk("resp_port", port, e.port);
            done_cnt[port]++;
            case (port)
              0: begin
                chk("icache_data", bus.icache_data, e.data);
                if (lat_chk) chk("latency", cyc - ic_raise_cyc, 3);
              end
              1: chk("dcache_rdata", bus.dcache_rdata, e.data);
              default: chk("io_rdata", bus.io_rdata, e.data[7:0]);
            endcase
            case (e.port)
              0: last_ic = e.data;
              1: last_dc = e.data;
              default: last_io = e.data[7:0];
            endcase
          end
        end
        if (!bus.icache_ready) chk("icache_hold", bus.icache_data, last_ic);
        if (!bus.dcache_ready) chk("dcache_hold", bus.dcache_rdata, last_dc);
        if (!bus.io_ready) chk("io_hold", bus.io_rdata, last_io);
        s_ic    = bus.icache_valid;
        s_dc    = bus.dcache_valid;
        s_io    = bus.io_valid && (!bus.io_rw || !bus.io_buffer_full);
        ev_prev = bus.eng_valid;
      end
    end
  end

  task automatic do_reset(input string name);
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk({name, "_eng_valid"}, bus.eng_valid, 0);
    chk({name, "_eng_kind"}, bus.eng_kind, 0);
    chk({name, "_eng_addr"}, bus.eng_addr, 0);
    chk({name, "_eng_wdata"}, bus.eng_wdata, 0);
    chk({name, "_icache_ready"}, bus.icache_ready, 0);
    chk({name, "_dcache_ready"}, bus.dcache_ready, 0);
    chk({name, "_io_ready"}, bus.io_ready, 0);
    chk({name, "_icache_data"}, bus.icache_data, 0);
    chk({name, "_dcache_rdata"}, bus.dcache_rdata, 0);
    chk({name, "_io_rdata"}, bus.io_rdata, 0);
    exp_q.delete();
    eng_busy = 0; done_real = 0;
    bus.icache_valid = 0; bus.dcache_valid = 0; bus.io_valid = 0;
    bus.eng_done = 0; bus.eng_ready = 0;
    m_starve = 0; m_last_dc = 1;
    s_ic = 0; s_dc = 0; s_io = 0; ev_prev = 0;
    last_ic = '0; last_dc = '0; last_io = '0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    #2 rst = 1;
  endtask

  task automatic drain(input string name);
    int t = 0;
    ic_pct = 0; dc_pct = 0; io_pct = 0; full_force = 0; full_pct = 0;
    rdy_pct = 100; erdy_pct = 100; spur_pct = 0;
    while ((bus.icache_valid || bus.dcache_valid || bus.io_valid || eng_busy || exp_q.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk({"drain_", name}, (t < 400), 1);
  endtask

  task automatic wait_valid(input bit need_io, input string name);
    int t = 0;
    while (!(bus.icache_valid && (!need_io || bus.io_valid)) && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk({"wait_", name}, (t < 50), 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, c1, t;
    ic_pct = 0; dc_pct = 0; io_pct = 0; dc_mode = 2; io_mode = 2;
    rdy_pct = 100; erdy_pct = 100; full_pct = 0; spur_pct = 0;
    dly_min = 0; dly_max = 0;
    full_force = 0; ic_fix = 0; io_fix = 0; rd_fix = 0; lat_chk = 0;
    do_reset("reset");

    // single icache line read at 0x1234, done 17 cycles after acceptance
    ic_fix = 1; rd_fix = 1; dly_min = 17; dly_max = 17;
    c0 = done_cnt[0];
    ic_pct = 100;
    wait_valid(0, "single");
    ic_pct = 0;
    drain("single");
    chk("single_ic_count", done_cnt[0] - c0, 1);
    ic_fix = 0; rd_fix = 0;

    // back-to-back icache with immediate engine: three-cycle latency
    dly_min = 0; dly_max = 0; lat_chk = 1; ic_pct = 100;
    repeat (40) @(negedge clk);
    drain("latency");
    lat_chk = 0;

    // both caches continuously requesting
    c0 = done_cnt[0]; c1 = done_cnt[1];
    ic_pct = 100; dc_pct = 100; dc_mode = 2; erdy_pct = 70; rdy_pct = 90; dly_min = 0; dly_max = 3;
    repeat (100) @(negedge clk);
    drain("tie");
    chk("tie_ic_served", (done_cnt[0] > c0), 1);
    chk("tie_dc_served", (done_cnt[1] > c1), 1);

    // io read stream against a pending dcache write
    c1 = done_cnt[1];
    io_pct = 100; io_mode = 0; dc_pct = 100; dc_mode = 1; dly_min = 0; dly_max = 1;
    repeat (150) @(negedge clk);
    drain("starve");
    chk("starve_dc_served", (done_cnt[1] > c1), 1);

    // io write blocked by a full buffer while icache waits
    c0 = done_cnt[2];
    io_fix = 1; full_force = 1; dly_min = 0; dly_max = 0;
    ic_pct = 100; io_pct = 100;
    wait_valid(1, "full");
    ic_pct = 0; io_pct = 0;
    repeat (5) @(posedge clk);
    drain("full");
    chk("full_io_served", done_cnt[2] - c0, 1);
    io_fix = 0;

    // fully random traffic with stalls and spurious engine completions
    for (int blk = 0; blk < 15; blk++) begin
      ic_pct = $urandom_range(80, 0); dc_pct = $urandom_range(80, 0); io_pct = $urandom_range(80, 0);
      dc_mode = 2; io_mode = 2; full_pct = $urandom_range(50, 0); spur_pct = 10;
      rdy_pct = $urandom_range(100, 60); erdy_pct = $urandom_range(100, 30);
      dly_min = 0; dly_max = $urandom_range(6, 0);
      repeat (100) @(negedge clk);
    end
    drain("random");

    // reset while a dcache read sits in WAIT
    dc_pct = 100; dc_mode = 0; dly_min = 20; dly_max = 20;
    t = 0;
    while (!eng_busy && t < 60) begin @(negedge clk); t++; end
    chk("wait_busy", (t < 60), 1);
    dc_pct = 0;
    repeat (3) @(negedge clk);
    do_reset("midreset");
    dly_min = 0; dly_max = 2;

    // first tie after reset must go to icache
    ic_pct = 100; dc_pct = 100; dc_mode = 2;
    repeat (40) @(negedge clk);
    drain("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Schedules the single memory transfer engine among three requesters: instruction cache line reads, data cache line reads/writes, and byte-wide IO reads/writes. The block sits between the cache/IO front ends and the byte-serial RAM transfer engine. It grants one request at a time and presents the granted request to the engine with a valid/ready handshake. When the engine finishes, it returns the result to the owner as a one-cycle ready pulse. IO has priority, with a starvation guard for the caches; icache and dcache share round-robin.

## Interface
- ADDR_WIDTH, 32, address width
- LINE_WIDTH, 128, cache line width in bits (16 bytes)
- STARVE_LIMIT, 4, consecutive IO grants allowed while a cache request waits

- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-low reset; one clock domain
- rdy  in  1  global enable; when 0 every register holds its value
- io_buffer_full  in  1  IO write buffer full; IO writes are ineligible while 1
- icache_valid / icache_addr  in  1 / ADDR_WIDTH  line read request
- icache_ready / icache_data  out  1 / LINE_WIDTH  completion pulse, line data
- dcache_valid / dcache_rw / dcache_addr / dcache_wdata  in  1 / 1 / ADDR_WIDTH / LINE_WIDTH  line request, rw=1 write
- dcache_ready / dcache_rdata  out  1 / LINE_WIDTH  completion pulse, read data
- io_valid / io_rw / io_addr / io_wdata  in  1 / 1 / ADDR_WIDTH / 8  byte request, rw=1 write
- io_ready / io_rdata  out  1 / 8  completion pulse, read byte
- eng_valid / eng_kind / eng_addr / eng_wdata  out  1 / 2 / ADDR_WIDTH / LINE_WIDTH  engine command; kind 0=line read, 1=line write, 2=byte read, 3=byte write
- eng_ready  in  1  engine accepts command this cycle
- eng_done / eng_rdata  in  1 / LINE_WIDTH  engine completion, read data

## Operation
- FSM states:
  - IDLE: arbitrate. On a grant, latch owner, kind, addr and wdata, then go to ISSUE. With no eligible request, stay in IDLE.
  - ISSUE: eng_valid=1. When eng_ready=1, go to WAIT.
  - WAIT: when eng_done=1, capture eng_rdata and go to RESP.
  - RESP: the owner's ready=1 and its data output is valid. Next state is IDLE.
- eng_done is ignored outside WAIT.
- Eligibility:
  - icache: icache_valid.
  - dcache: dcache_valid.
  - io: io_valid && (!io_rw || !io_buffer_full).
- Arbitration priority: io first. If starve_cnt==STARVE_LIMIT and a cache request is eligible, the cache wins.
- Cache tie-break: when both caches are eligible, grant the one not recorded in last_cache. last_cache updates on every cache grant.
- starve_cnt, 3 bits:
  - increments on an io grant while any cache request is eligible;
  - clears on a cache grant or when no cache request is eligible;
  - saturates at STARVE_LIMIT.
- Address forming:
  - line requests: eng_addr = {addr[ADDR_WIDTH-1:4], 4'b0};
  - io requests: addr passes through unmodified.
- Byte transfers: eng_wdata = {120'b0, io_wdata}; io_rdata = eng_rdata[7:0].
- Command stability: eng_* outputs hold stable from ISSUE entry until the eng_ready handshake.
- Requester obligations:
  - hold valid and payload until ready is seen;
  - drop valid at the edge ending the RESP cycle.
- No arbitration occurs in RESP, so a completed request is never re-granted.
- Data outputs (icache_data, dcache_rdata, io_rdata) hold their last value until the next completion for that port.

## Timing
- Reset values (asynchronous, rst=0):
  - state=IDLE;
  - all ready outputs, eng_valid and eng_kind = 0;
  - all data outputs, eng_addr and eng_wdata = 0;
  - starve_cnt=0;
  - last_cache=dcache, so icache wins the first tie.
- Reset mid-transaction: eng_valid drops immediately. The engine shares the same reset, so nothing is replayed.
- Minimum latency, with eng_ready high in the first ISSUE cycle and eng_done high in the first WAIT cycle:
  - request valid in cycle 0 (IDLE);
  - cycle 1: ISSUE;
  - cycle 2: WAIT;
  - cycle 3: RESP with ready=1.
- Ready outputs are registered and high for exactly one enabled cycle. Only one ready is high at a time.
- rdy=0 freezes the FSM, counters and outputs. A ready pulse stretches across disabled cycles.
- io write with io_buffer_full=1: the io request is ineligible and caches may be granted meanwhile. The grant occurs in the first IDLE cycle with the buffer not full.

## Test plan
- Single icache read of addr 0x0000_1234 (eng_ready immediate, done after 17 cycles, rdata 0x00112233_44556677_8899AABB_CCDDEEFF):
  - -> eng_kind=0 and eng_addr=0x0000_1230;
  - -> icache_ready pulses once with icache_data equal to that rdata.
- icache and dcache valid together, both continuously re-requesting:
  - -> grants alternate icache, dcache, icache, …;
  - -> no two consecutive grants go to the same cache.
- io read stream held continuously together with a pending dcache write, STARVE_LIMIT=4:
  - -> 4 io grants, then a dcache grant (eng_kind=1, eng_wdata=dcache_wdata), then io resumes.
- io write of 0x41 to addr 0x0003_0000 with io_buffer_full=1 for 5 cycles while icache is valid:
  - -> icache is served first;
  - -> io is issued with eng_kind=3 and eng_wdata[7:0]=0x41 only after io_buffer_full falls.
- eng_ready held low for 3 cycles in ISSUE, rdy=0 for 2 cycles in RESP:
  - -> eng_valid and the command stay stable throughout;
  - -> the ready pulse spans the disabled cycles plus one enabled cycle.
- rst asserted during WAIT of a dcache read:
  - -> all outputs are 0 asynchronously;
  - -> after release, the FSM is in IDLE and the first icache/dcache tie goes to icache.
